sccb_write_master: RTL and testbench

SCCB_WRITE_MASTER -- requirements
Module: sccb_write_master

---
 rtl/sccb_write_master.sv | 170 +++++++++++++++++
 tb/tb_sccb_write_master.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_write_master.sv
// SCCB write master: sends slave address, register address and value as three
// acknowledged bytes. SCL is push-pull, SDA is open-drain; one SCL quarter = D iCLK cycles.
module sccb_write_master #(
    parameter int CLK_Freq = 50000000,
    parameter int I2C_Freq = 100000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [23:0] iDATA,
    input  logic        iGO,
    output logic        oBUSY,
    output logic        oEND,
    output logic        oACK,
    output logic        I2C_SCLK,
    inout  wire         I2C_SDAT
);
    // state | meaning
    // IDLE  | bus idle, waiting for iGO with oEND low
    // START | 2 ticks: SDA released, then pulled low while SCL high
    // BIT   | 27 slots of 4 ticks: 3 x (8 data bits MSB first + ack slot)
    // STOP  | 3 ticks: SCL low/SDA low, SCL high/SDA low, SCL high/SDA released
    // DONE  | oEND high until iGO is seen low
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_BIT   = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int D  = CLK_Freq / (4 * I2C_Freq);
    localparam int CW = (D > 1) ? $clog2(D) : 1;

    if (D < 2) begin : g_bad_divider
        $error("sccb_write_master: CLK_Freq/(4*I2C_Freq) must be at least 2");
    end

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          tick;
    logic [23:0]   shreg;
    logic [1:0]    phase;
    logic [3:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic          sda_oe;
    logic          nack;

    assign tick     = oBUSY && (cnt == CW'(D - 1));
    assign I2C_SDAT = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt <= '0;
        end else if (!oBUSY || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            phase    <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            sda_oe   <= 1'b0;
            nack     <= 1'b0;
            oBUSY    <= 1'b0;
            oEND     <= 1'b0;
            oACK     <= 1'b0;
            I2C_SCLK <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iGO && !oEND) begin
                        shreg <= iDATA;
                        oBUSY <= 1'b1;
                        oACK  <= 1'b0;
                        nack  <= 1'b0;
                        phase <= 2'd0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (phase == 2'd0) begin
                            phase  <= 2'd1;
                            sda_oe <= 1'b1;
                        end else begin
                            state    <= ST_BIT;
                            phase    <= 2'd0;
                            bit_idx  <= 4'd0;
                            byte_idx <= 2'd0;
                            I2C_SCLK <= 1'b0;
                            sda_oe   <= ~shreg[23];
                            shreg    <= {shreg[22:0], 1'b0};
                        end
                    end
                end
                ST_BIT: begin
                    if (tick) begin
                        case (phase)
                            2'd0: phase <= 2'd1;
                            2'd1: begin
                                phase    <= 2'd2;
                                I2C_SCLK <= 1'b1;
                            end
                            2'd2: begin
                                phase <= 2'd3;
                                if (bit_idx == 4'd8 && I2C_SDAT) nack <= 1'b1;
                            end
                            default: begin
                                // SDA moves together with the SCL falling edge, never while SCL is high
                                phase    <= 2'd0;
                                I2C_SCLK <= 1'b0;
                                if (bit_idx == 4'd8) begin
                                    bit_idx <= 4'd0;
                                    if (byte_idx == 2'd2) begin
                                        state  <= ST_STOP;
                                        sda_oe <= 1'b1;
                                    end else begin
                                        byte_idx <= byte_idx + 2'd1;
                                        sda_oe   <= ~shreg[23];
                                        shreg    <= {shreg[22:0], 1'b0};
                                    end
                                end else begin
                                    bit_idx <= bit_idx + 4'd1;
                                    if (bit_idx == 4'd7) begin
                                        sda_oe <= 1'b0;
                                    end else begin
                                        sda_oe <= ~shreg[23];
                                        shreg  <= {shreg[22:0], 1'b0};
                                    end
                                end
                            end
                        endcase
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        case (phase)
                            2'd0: begin
                                phase    <= 2'd1;
                                I2C_SCLK <= 1'b1;
                            end
                            2'd1: begin
                                phase  <= 2'd2;
                                sda_oe <= 1'b0;
                            end
                            default: begin
                                phase <= 2'd0;
                                oBUSY <= 1'b0;
                                oEND  <= 1'b1;
                                oACK  <= nack;
                                state <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_DONE: begin
                    if (!iGO) begin
                        oEND  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sccb_write_master.sv
// Bench for sccb_write_master at D=2: bus monitor with an acking slave, and a
// byte-level reference model of the expected SDA stream and status outputs.
module tb_sccb_write_master;
    localparam int D         = 800 / (4 * 100);
    localparam int EXP_BUSY  = 113 * D;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic [23:0] data = '0;
    logic        busy, done, ack, sclk;
    wire         sda;
    logic        slave_drv = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pullup (sda);
    assign sda = slave_drv ? 1'b0 : 1'bz;

    sccb_write_master #(.CLK_Freq(800), .I2C_Freq(100)) dut (
        .iCLK     (clk),
        .iRST_N   (rst_n),
        .iDATA    (data),
        .iGO      (go),
        .oBUSY    (busy),
        .oEND     (done),
        .oACK     (ack),
        .I2C_SCLK (sclk),
        .I2C_SDAT (sda)
    );

    // Bus monitor and slave: captures SDA at each SCL rise, counts start/stop
    // conditions, and pulls SDA low for the ack slot of each byte enabled in ack_mask.
    logic       prev_sclk = 1'b1;
    logic       prev_sda = 1'b1;
    logic       cap_q[$];
    int         n_start = 0;
    int         n_stop = 0;
    int         rise_cnt = 0;
    logic [2:0] ack_mask = 3'b111;

    always @(negedge clk or negedge rst_n) begin
        logic s;
        int   k;
        s = (sda === 1'b0) ? 1'b0 : 1'b1;
        if (!rst_n) begin
            slave_drv = 1'b0;
            rise_cnt  = 0;
        end else begin
            if (prev_sclk && sclk && prev_sda && !s) begin
                n_start++;
                rise_cnt = 0;
            end
            if (prev_sclk && sclk && !prev_sda && s) n_stop++;
            if (!prev_sclk && sclk) begin
                cap_q.push_back(s);
                rise_cnt++;
            end
            if (prev_sclk && !sclk) begin
                k = rise_cnt / 9;
                if (rise_cnt < 27 && (rise_cnt % 9) == 8) slave_drv = ack_mask[2 - k];
                else slave_drv = 1'b0;
            end
        end
        prev_sclk = sclk;
        prev_sda  = s;
    end

    // SDA value at each SCL rise: 3 x (8 data bits MSB first, ack bit), then the stop's rise with SDA low.
    function automatic logic [27:0] model_bits(input logic [23:0] d, input logic [2:0] mask);
        logic [27:0] v;
        logic [7:0]  bytes [3];
        bytes[0] = d[23:16];
        bytes[1] = d[15:8];
        bytes[2] = d[7:0];
        v = '0;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 8; i++) v[27 - b*9 - i] = bytes[b][7 - i];
            v[27 - b*9 - 8] = ~mask[2 - b];
        end
        v[0] = 1'b0;
        return v;
    endfunction

    function automatic logic [27:0] captured(input int si);
        logic [27:0] v;
        v = 'x;
        for (int i = 0; i < 28; i++)
            if (si + i < cap_q.size()) v[27 - i] = cap_q[si + i];
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Requests one transfer and measures it; iDATA is scrambled right after the latch.
    task automatic do_transfer(input logic [23:0] d, input logic [2:0] mask, input int drop_at,
                               output int bc, output logic e, output logic a,
                               output int si, output int st0, output int sp0);
        int guard;
        ack_mask = mask;
        si  = cap_q.size();
        st0 = n_start;
        sp0 = n_stop;
        data = d;
        go   = 1'b1;
        guard = 0;
        while (!busy && guard < 20) begin
            step(1);
            guard++;
        end
        data = 24'($urandom);
        bc = 0;
        while (busy && bc < 2000) begin
            bc++;
            if (bc == drop_at) go = 1'b0;
            step(1);
        end
        e = done;
        a = ack;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        go    = 1'b0;
        step(3);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_end got %b exp 0", done); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", ack); end
        checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk got %b exp 1", sclk); end
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda got %b exp 1", sda); end
        rst_n = 1'b1;
        step(4);
        checks++; if (busy !== 1'b0 || sclk !== 1'b1) begin errors++; $display("FAIL idle_after_reset busy=%b sclk=%b exp 0/1", busy, sclk); end
    endtask

    task automatic test_basic();
        int bc, si, st0, sp0;
        logic e, a;
        logic [27:0] exp_v, got_v;
        do_transfer(24'h421280, 3'b111, -1, bc, e, a, si, st0, sp0);
        exp_v = model_bits(24'h421280, 3'b111);
        got_v = captured(si);
        checks++; if (bc != EXP_BUSY) begin errors++; $display("FAIL basic_busy got %0d exp %0d", bc, EXP_BUSY); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL basic_end got %b exp 1", e); end
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL basic_ack got %b exp 0", a); end
        checks++; if (cap_q.size() - si != 28) begin errors++; $display("FAIL basic_rises got %0d exp 28", cap_q.size() - si); end
        checks++; if (got_v !== exp_v) begin errors++; $display("FAIL basic_bits got %h exp %h", got_v, exp_v); end
        checks++; if (n_start - st0 != 1 || n_stop - sp0 != 1) begin errors++; $display("FAIL basic_startstop got %0d/%0d exp 1/1", n_start - st0, n_stop - sp0); end
        go = 1'b0;
        step(1);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_end_clear got %b exp 0", done); end
    endtask

    // Register-address byte NACKed, then iGO held with oEND high, then a fresh transfer.
    task automatic test_nack_and_hold();
        int bc, si, st0, sp0, bad;
        logic e, a;
        logic [23:0] d;
        logic [27:0] exp_v, got_v;
        d = {8'h42, 16'($urandom)};
        do_transfer(d, 3'b101, -1, bc, e, a, si, st0, sp0);
        exp_v = model_bits(d, 3'b101);
        got_v = captured(si);
        checks++; if (bc != EXP_BUSY) begin errors++; $display("FAIL nack_busy got %0d exp %0d", bc, EXP_BUSY); end
        checks++; if (e !== 1'b1 || a !== 1'b1) begin errors++; $display("FAIL nack_end_ack got %b/%b exp 1/1", e, a); end
        checks++; if (got_v !== exp_v) begin errors++; $display("FAIL nack_bits got %h exp %h", got_v, exp_v); end
        checks++; if (n_stop - sp0 != 1) begin errors++; $display("FAIL nack_stop got %0d exp 1", n_stop - sp0); end
        st0 = n_start;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (done !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL hold_end_level got %0d bad cycles exp 0", bad); end
        checks++; if (n_start != st0) begin errors++; $display("FAIL hold_no_start got %0d exp %0d", n_start, st0); end
        go = 1'b0;
        step(1);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL hold_end_clear got %b exp 0", done); end
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL hold_ack_kept got %b exp 1", ack); end
        do_transfer(24'h42703A, 3'b111, -1, bc, e, a, si, st0, sp0);
        exp_v = model_bits(24'h42703A, 3'b111);
        got_v = captured(si);
        checks++; if (bc != EXP_BUSY) begin errors++; $display("FAIL second_busy got %0d exp %0d", bc, EXP_BUSY); end
        checks++; if (e !== 1'b1 || a !== 1'b0) begin errors++; $display("FAIL second_end_ack got %b/%b exp 1/0", e, a); end
        checks++; if (got_v !== exp_v) begin errors++; $display("FAIL second_bits got %h exp %h", got_v, exp_v); end
        go = 1'b0;
        step(1);
    endtask

    task automatic test_go_drop();
        int bc, si, st0, sp0;
        logic e, a;
        logic [23:0] d;
        logic [27:0] exp_v, got_v;
        d = 24'($urandom);
        do_transfer(d, 3'b011, 10, bc, e, a, si, st0, sp0);
        exp_v = model_bits(d, 3'b011);
        got_v = captured(si);
        checks++; if (bc != EXP_BUSY) begin errors++; $display("FAIL drop_busy got %0d exp %0d", bc, EXP_BUSY); end
        checks++; if (e !== 1'b1 || a !== 1'b1) begin errors++; $display("FAIL drop_end_ack got %b/%b exp 1/1", e, a); end
        checks++; if (got_v !== exp_v) begin errors++; $display("FAIL drop_bits got %h exp %h", got_v, exp_v); end
        step(1);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL drop_end_pulse got %b exp 0", done); end
    endtask

    task automatic test_reset_mid();
        int bc, si, st0, sp0, guard;
        logic e, a;
        logic [27:0] exp_v, got_v;
        ack_mask = 3'b111;
        data = {8'h42, 16'($urandom)};
        go = 1'b1;
        guard = 0;
        while (!busy && guard < 20) begin
            step(1);
            guard++;
        end
        step($urandom_range(78, 136));
        rst_n = 1'b0;
        #1;
        checks++; if (sclk !== 1'b1 || sda !== 1'b1) begin errors++; $display("FAIL midrst_bus sclk=%b sda=%b exp 1/1", sclk, sda); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_status busy=%b end=%b exp 0/0", busy, done); end
        go = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
        do_transfer(24'h421204, 3'b111, -1, bc, e, a, si, st0, sp0);
        exp_v = model_bits(24'h421204, 3'b111);
        got_v = captured(si);
        checks++; if (bc != EXP_BUSY) begin errors++; $display("FAIL postrst_busy got %0d exp %0d", bc, EXP_BUSY); end
        checks++; if (e !== 1'b1 || a !== 1'b0) begin errors++; $display("FAIL postrst_end_ack got %b/%b exp 1/0", e, a); end
        checks++; if (got_v !== exp_v) begin errors++; $display("FAIL postrst_bits got %h exp %h", got_v, exp_v); end
        checks++; if (n_start - st0 != 1 || n_stop - sp0 != 1) begin errors++; $display("FAIL postrst_startstop got %0d/%0d exp 1/1", n_start - st0, n_stop - sp0); end
        go = 1'b0;
        step(1);
    endtask

    task automatic test_random();
        int bc, si, st0, sp0;
        logic e, a;
        logic [23:0] d;
        logic [2:0]  m;
        logic [27:0] exp_v, got_v;
        for (int n = 0; n < 6; n++) begin
            d = 24'($urandom);
            m = 3'($urandom_range(0, 7));
            do_transfer(d, m, -1, bc, e, a, si, st0, sp0);
            exp_v = model_bits(d, m);
            got_v = captured(si);
            checks++; if (bc != EXP_BUSY) begin errors++; $display("FAIL rand%0d_busy got %0d exp %0d", n, bc, EXP_BUSY); end
            checks++; if (e !== 1'b1 || a !== (m != 3'b111)) begin errors++; $display("FAIL rand%0d_end_ack got %b/%b exp 1/%b", n, e, a, m != 3'b111); end
            checks++; if (got_v !== exp_v) begin errors++; $display("FAIL rand%0d_bits got %h exp %h", n, got_v, exp_v); end
            checks++; if (n_start - st0 != 1 || n_stop - sp0 != 1) begin errors++; $display("FAIL rand%0d_startstop got %0d/%0d exp 1/1", n, n_start - st0, n_stop - sp0); end
            go = 1'b0;
            step(1 + $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nack_and_hold();
        test_go_drop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
